// File: rtl/alu_mem_unit.sv
// Datapath slice: combinational ALU with status flags
// plus a single-port RAM (sync write, async read).
module alu_mem_unit #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      alu_a,
   input  logic [WIDTH-1:0]      alu_b,
   input  logic [3:0]            alu_opcode,
   output logic [WIDTH-1:0]      alu_result,
   output logic                  carry_flag,
   output logic                  zero_flag,
   output logic                  overflow_flag,
   output logic                  sign_flag,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_din,
   output logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b001,
      OP_NOT = 3'b010
   } alu_op_e;

   logic [2:0]     op_sel;
   logic [WIDTH:0] sum;
   logic           unused_dst;

   // bit 0 is the CPU's destination select, not an ALU control
   assign op_sel     = alu_opcode[3:1];
   assign unused_dst = alu_opcode[0];
   assign sum        = {1'b0, alu_a} + {1'b0, alu_b};

   always_comb begin
      alu_result    = alu_a;
      carry_flag    = 1'b0;
      overflow_flag = 1'b0;
      case (op_sel)
         OP_ADD: begin
            alu_result    = sum[WIDTH-1:0];
            carry_flag    = sum[WIDTH];
            overflow_flag = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != alu_a[WIDTH-1]);
         end
         OP_AND:  alu_result = alu_a & alu_b;
         OP_NOT:  alu_result = ~alu_a;
         default: alu_result = alu_a;
      endcase
   end

   assign zero_flag = (alu_result == '0);
   assign sign_flag = alu_result[WIDTH-1];

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (mem_we) begin
         mem_d[mem_addr] = mem_din;
      end
   end

   // async clear holds every word at zero while reset is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign mem_dout = mem_q[mem_addr];

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed bench for alu_mem_unit: ALU vector table
// plus RAM write/read/reset sequences.
module tb_alu_mem_unit;

   logic       clk;
   logic       reset;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_opcode;
   logic [7:0] alu_result;
   logic       carry_flag;
   logic       zero_flag;
   logic       overflow_flag;
   logic       sign_flag;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;

   int total = 0;
   int bad   = 0;

   alu_mem_unit dut (
      .clk           (clk),
      .reset         (reset),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_opcode    (alu_opcode),
      .alu_result    (alu_result),
      .carry_flag    (carry_flag),
      .zero_flag     (zero_flag),
      .overflow_flag (overflow_flag),
      .sign_flag     (sign_flag),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_din       (mem_din),
      .mem_dout      (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       v;
      logic       s;
   } alu_vec_t;

   alu_vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp,
                     input string name);
      mem_addr = addr;
      #1;
      check(name, {24'd0, mem_dout}, {24'd0, exp});
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data,
                     input logic [7:0] old, input string name);
      @(negedge clk);
      mem_we   = 1'b1;
      mem_addr = addr;
      mem_din  = data;
      #1;
      check({name, "_pre"}, {24'd0, mem_dout}, {24'd0, old});
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      check({name, "_post"}, {24'd0, mem_dout}, {24'd0, data});
   endtask

   initial begin
      //          a      b      op       res    c     z     v     s
      vecs[0]  = '{8'd100, 8'd27,  4'b0000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{8'd200, 8'd100, 4'b0000, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{8'd127, 8'd1,   4'b0000, 8'd128, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{8'd255, 8'd1,   4'b0000, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{8'hF0,  8'h3C,  4'b0010, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{8'h0F,  8'hF0,  4'b0010, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{8'h00,  8'h55,  4'b0100, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{8'hFF,  8'h12,  4'b0100, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{8'h81,  8'h42,  4'b1110, 8'h81,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{8'd100, 8'd27,  4'b0001, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{8'd127, 8'd1,   4'b0001, 8'd128, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{8'hF0,  8'h3C,  4'b0011, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{8'h00,  8'h55,  4'b0101, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{8'hFF,  8'h12,  4'b0101, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{8'h00,  8'hFF,  4'b1111, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{8'h7E,  8'h7E,  4'b0110, 8'h7E,  1'b0, 1'b0, 1'b0, 1'b0};

      reset      = 1'b1;
      alu_a      = '0;
      alu_b      = '0;
      alu_opcode = '0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_din    = '0;

      for (int i = 0; i < 16; i++) begin
         alu_a      = vecs[i].a;
         alu_b      = vecs[i].b;
         alu_opcode = vecs[i].op;
         #1;
         check($sformatf("alu_vec%0d", i),
               {20'd0, alu_result, carry_flag, zero_flag,
                overflow_flag, sign_flag},
               {20'd0, vecs[i].res, vecs[i].c, vecs[i].z,
                vecs[i].v, vecs[i].s});
      end

      @(negedge clk);
      rd(8'h10, 8'h00, "rst_rd10");
      rd(8'hFF, 8'h00, "rst_rdFF");
      @(negedge clk);
      reset = 1'b0;

      wr(8'h10, 8'h5A, 8'h00, "wr10");
      wr(8'hFF, 8'hA5, 8'h00, "wrFF");
      wr(8'h00, 8'h01, 8'h00, "wr00");
      wr(8'h10, 8'hC3, 8'h5A, "wr10b");
      wr(8'h10, 8'h5A, 8'hC3, "wr10c");

      @(negedge clk);
      rd(8'h10, 8'h5A, "rd10");
      rd(8'hFF, 8'hA5, "rdFF");
      rd(8'h00, 8'h01, "rd00");
      rd(8'h11, 8'h00, "rd11");

      // async reset pulse between edges
      @(posedge clk);
      #2;
      reset = 1'b1;
      rd(8'h10, 8'h00, "arst10");
      rd(8'hFF, 8'h00, "arstFF");
      rd(8'h00, 8'h00, "arst00");

      @(negedge clk);
      mem_we   = 1'b1;
      mem_addr = 8'h10;
      mem_din  = 8'h77;
      @(posedge clk);
      #1;
      check("wr_in_reset", {24'd0, mem_dout}, 32'd0);

      @(negedge clk);
      reset   = 1'b0;
      mem_din = 8'h33;
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      check("wr_after_reset", {24'd0, mem_dout}, 32'h33);
      rd(8'hFF, 8'h00, "after_rstFF");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
